rs_syndrome: RTL and testbench

//  First stage of the RS receive path, paired with the rs_encoder/rs_lfsr transmit chain.
//  - Takes one received codeword stream of N_NUM symbols, one symbol per din_val beat.
//  - Computes all R_NUM syndromes S_j = r(alpha^(FCR+j)), j=0..R_NUM-1, by per-root Horner recursion.
//  - Reports the syndromes plus a nonzero flag, and passes the data through to the later BM/Chien stages.

---
 rtl/rs_pkg.sv | 31 +++
 rtl/rs_gf_cmul.sv | 29 ++
 rtl/rs_syndrome.sv | 133 +++++++++++++
 tb/tb_rs_syndrome.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: default field parameters, FSM state type
// and the GF alpha-power constant function used to build the constant multipliers.
package rs_pkg;

    localparam int SYM_BW_DEF = 8;
    localparam int PRIM_DEF   = 'h11D;
    localparam int CNT_BW     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rs_state_t;

    // alpha^exp in GF(2^sym_bw) reduced by prim, evaluated at elaboration time
    function automatic int gf_alpha_pow(input int exp, input int sym_bw, input int prim);
        int v;
        int e;
        int ord;
        ord = (1 << sym_bw) - 1;
        e   = exp % ord;
        v   = 1;
        for (int k = 0; k < e; k++) begin
            v = v << 1;
            if ((v & (1 << sym_bw)) != 0) begin
                v = v ^ prim;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// Constant GF(2^SYM_BW) multiplier: dout = din * alpha^EXP.
// Each input bit i selects the constant column alpha^(EXP+i); the columns are XORed.
module rs_gf_cmul
    import rs_pkg::*;
#(
    parameter int SYM_BW = SYM_BW_DEF,
    parameter int PRIM   = PRIM_DEF,
    parameter int EXP    = 0
) (
    input  logic [SYM_BW-1:0] din,
    output logic [SYM_BW-1:0] dout
);

    logic [SYM_BW-1:0] terms [SYM_BW];

    for (genvar i = 0; i < SYM_BW; i++) begin : g_col
        localparam int COL_VAL = gf_alpha_pow(EXP + i, SYM_BW, PRIM);
        assign terms[i] = din[i] ? SYM_BW'(COL_VAL) : '0;
    end

    // XOR tree over the selected constant columns
    always_comb begin
        dout = '0;
        for (int i = 0; i < SYM_BW; i++) begin
            dout = dout ^ terms[i];
        end
    end

endmodule

// File: rtl/rs_syndrome.sv
// RS syndrome calculator: Horner recursion per root over one codeword of
// N_NUM symbols, with a one-cycle registered data passthrough.
// Optional feature macro: RS_SYND_PARITY_STRIP_EN (drop parity symbols from dout).
module rs_syndrome
    import rs_pkg::*;
#(
    parameter int SYM_BW = SYM_BW_DEF,
    parameter int N_NUM  = 255,
    parameter int R_NUM  = 16,
    parameter int FCR    = 0,
    parameter int PRIM   = PRIM_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_val,
    input  logic                    din_sop,
    input  logic [SYM_BW-1:0]       din,
    output logic                    dout_val,
    output logic                    dout_sop,
    output logic                    dout_eop,
    output logic [SYM_BW-1:0]       dout,
    output logic                    synd_val,
    output logic [R_NUM*SYM_BW-1:0] synd,
    output logic                    synd_nz,
    output logic                    frame_abort
);

    localparam logic [CNT_BW-1:0] LAST_IDX = CNT_BW'(N_NUM - 1);
`ifdef RS_SYND_PARITY_STRIP_EN
    localparam logic [CNT_BW-1:0] PASS_LAST = CNT_BW'(N_NUM - R_NUM - 1);
`else
    localparam logic [CNT_BW-1:0] PASS_LAST = CNT_BW'(N_NUM - 1);
`endif

    rs_state_t                 state, state_next;
    logic [CNT_BW-1:0]         cnt, cnt_next;
    logic [SYM_BW-1:0]         s_reg   [R_NUM];
    logic [SYM_BW-1:0]         s_next  [R_NUM];
    logic [SYM_BW-1:0]         mul_out [R_NUM];
    logic [R_NUM*SYM_BW-1:0]   s_flat;
    logic [CNT_BW-1:0]         beat_idx;
    logic                      accept;
    logic                      last;
    logic                      abort_next;

    for (genvar j = 0; j < R_NUM; j++) begin : g_root
        rs_gf_cmul #(
            .SYM_BW (SYM_BW),
            .PRIM   (PRIM),
            .EXP    (FCR + j)
        ) u_cmul (
            .din  (s_reg[j]),
            .dout (mul_out[j])
        );
    end

    // Next-state, Horner update and beat classification
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        beat_idx   = '0;
        abort_next = 1'b0;
        s_flat     = '0;
        for (int j = 0; j < R_NUM; j++) begin
            s_next[j] = s_reg[j];
        end
        if (din_val) begin
            if (din_sop) begin
                accept     = 1'b1;
                cnt_next   = CNT_BW'(1);
                state_next = RUN;
                abort_next = (state == RUN);
                for (int j = 0; j < R_NUM; j++) begin
                    s_next[j] = din;
                end
            end else if (state == RUN) begin
                accept   = 1'b1;
                beat_idx = cnt;
                cnt_next = cnt + CNT_BW'(1);
                for (int j = 0; j < R_NUM; j++) begin
                    s_next[j] = mul_out[j] ^ din;
                end
            end
        end
        last = accept && (beat_idx == LAST_IDX);
        if (last) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
        for (int j = 0; j < R_NUM; j++) begin
            s_flat[j*SYM_BW +: SYM_BW] = s_next[j];
        end
    end

    // State, accumulators, passthrough and syndrome result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            for (int j = 0; j < R_NUM; j++) begin
                s_reg[j] <= '0;
            end
            dout_val    <= 1'b0;
            dout_sop    <= 1'b0;
            dout_eop    <= 1'b0;
            dout        <= '0;
            synd_val    <= 1'b0;
            synd        <= '0;
            synd_nz     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            for (int j = 0; j < R_NUM; j++) begin
                s_reg[j] <= s_next[j];
            end
            dout_val    <= accept && (beat_idx <= PASS_LAST);
            dout_sop    <= accept && din_sop;
            dout_eop    <= accept && (beat_idx == PASS_LAST);
            if (accept) begin
                dout <= din;
            end
            synd_val    <= last;
            if (last) begin
                synd    <= s_flat;
                synd_nz <= |s_flat;
            end
            frame_abort <= abort_next;
        end
    end

endmodule

// File: tb/tb_rs_syndrome.sv
// Directed testbench for rs_syndrome with a bench-side GF model and encoder.
module tb_rs_syndrome;

    logic         clk = 1'b0;
    logic         rst;
    logic         din_val;
    logic         din_sop;
    logic [7:0]   din;
    logic         dout_val;
    logic         dout_sop;
    logic         dout_eop;
    logic [7:0]   dout;
    logic         synd_val;
    logic [127:0] synd;
    logic         synd_nz;
    logic         frame_abort;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_cyc     = 0;

    logic [7:0] cw  [255];
    logic [7:0] gen [17];

    int           pos        = 0;
    int           dout_beats = 0;
    int           dout_bad   = 0;
    int           eop_pos    = -1;
    int           eop_sync   = 0;
    int           synd_cnt   = 0;
    int           abort_cnt  = 0;
    int           synd_cyc   = 0;
    logic [127:0] synd_cap   = '0;
    logic         nz_cap     = 1'b0;

    int base_beats, base_synd, base_abort, base_bad, base_sync;

    rs_syndrome u_dut (
        .clk         (clk),
        .rst         (rst),
        .din_val     (din_val),
        .din_sop     (din_sop),
        .din         (din),
        .dout_val    (dout_val),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
        .dout        (dout),
        .synd_val    (synd_val),
        .synd        (synd),
        .synd_nz     (synd_nz),
        .frame_abort (frame_abort)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_val) begin
                if (dout_sop) pos = 0;
                if (pos < 255 && dout != cw[pos]) dout_bad++;
                if (dout_eop) eop_pos = pos;
                if (dout_eop && synd_val) eop_sync++;
                pos++;
                dout_beats++;
            end
            if (synd_val) begin
                synd_cnt++;
                synd_cap = synd;
                nz_cap   = synd_nz;
                synd_cyc = cyc;
            end
            if (frame_abort) abort_cnt++;
        end
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] alpha_pow(input int e);
        logic [7:0] v;
        v = 8'h01;
        for (int k = 0; k < e; k++) v = gf_mul(v, 8'h02);
        return v;
    endfunction

    function automatic logic [127:0] model_synd();
        logic [127:0] r;
        logic [7:0]   a;
        logic [7:0]   s;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            a = alpha_pow(j);
            s = 8'h00;
            for (int i = 0; i < 255; i++) s = gf_mul(s, a) ^ cw[i];
            r[j*8 +: 8] = s;
        end
        return r;
    endfunction

    task automatic build_gen();
        logic [7:0] root;
        for (int k = 0; k < 17; k++) gen[k] = 8'h00;
        gen[0] = 8'h01;
        for (int j = 0; j < 16; j++) begin
            root = alpha_pow(j);
            for (int k = 16; k >= 1; k--) gen[k] = gen[k-1] ^ gf_mul(gen[k], root);
            gen[0] = gf_mul(gen[0], root);
        end
    endtask

    task automatic encode_random();
        logic [7:0] rem [16];
        logic [7:0] fb;
        for (int k = 0; k < 16; k++) rem[k] = 8'h00;
        for (int i = 0; i < 239; i++) begin
            cw[i] = 8'($urandom_range(255));
            fb    = cw[i] ^ rem[15];
            for (int k = 15; k >= 1; k--) rem[k] = rem[k-1] ^ gf_mul(fb, gen[k]);
            rem[0] = gf_mul(fb, gen[0]);
        end
        for (int k = 0; k < 16; k++) cw[239+k] = rem[15-k];
    endtask

    task automatic clear_cw();
        for (int i = 0; i < 255; i++) cw[i] = 8'h00;
    endtask

    task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic snapshot();
        base_beats = dout_beats;
        base_synd  = synd_cnt;
        base_abort = abort_cnt;
        base_bad   = dout_bad;
        base_sync  = eop_sync;
    endtask

    task automatic drive_beat(input logic [7:0] d, input bit sop, input bit gaps);
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
                @(negedge clk);
                din_val = 1'b0;
                din_sop = 1'b0;
            end
        end
        @(negedge clk);
        din_val  = 1'b1;
        din_sop  = sop;
        din      = d;
        last_cyc = cyc;
    endtask

    task automatic apply_stimulus(input int n_sym, input bit gaps);
        for (int i = 0; i < n_sym; i++) drive_beat(cw[i], (i == 0), gaps);
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        din_val = 1'b0;
        din_sop = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [127:0] exp_synd, input logic exp_nz);
        check_output({tag, "_synd"}, synd_cap, exp_synd);
        check_output({tag, "_nz"}, 128'(nz_cap), 128'(exp_nz));
    endtask

    initial begin
        int exp_beats;
        int exp_eop;
        logic [127:0] exp;
`ifdef RS_SYND_PARITY_STRIP_EN
        exp_beats = 239;
        exp_eop   = 238;
`else
        exp_beats = 255;
        exp_eop   = 254;
`endif
        rst     = 1'b1;
        din_val = 1'b0;
        din_sop = 1'b0;
        din     = 8'h00;
        clear_cw();
        build_gen();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_output("rst_synd",     synd, '0);
        check_output("rst_synd_val", 128'(synd_val), '0);
        check_output("rst_synd_nz",  128'(synd_nz), '0);
        check_output("rst_dout_val", 128'(dout_val), '0);
        check_output("rst_abort",    128'(frame_abort), '0);

        // din_val without sop while idle is ignored
        snapshot();
        drive_beat(8'hAA, 1'b0, 1'b0);
        go_idle(3);
        check_output("idle_ignore_beats", 128'(dout_beats - base_beats), '0);

        // Case 1: valid codeword
        encode_random();
        snapshot();
        apply_stimulus(255, 1'b0);
        go_idle(3);
        check_output("cw_synd_cnt", 128'(synd_cnt - base_synd), 128'(1));
        check_frame("cw", '0, 1'b0);
        check_output("cw_dout_bad", 128'(dout_bad - base_bad), '0);
        check_output("cw_beats", 128'(dout_beats - base_beats), 128'(exp_beats));
        check_output("cw_eop_pos", 128'(eop_pos), 128'(exp_eop));
        check_output("cw_latency", 128'(synd_cyc - last_cyc), 128'(1));
`ifndef RS_SYND_PARITY_STRIP_EN
        check_output("cw_eop_sync", 128'(eop_sync - base_sync), 128'(1));
`endif

        // Back-to-back frames: sop right after the last symbol
        snapshot();
        apply_stimulus(255, 1'b0);
        apply_stimulus(255, 1'b0);
        go_idle(3);
        check_output("b2b_synd_cnt", 128'(synd_cnt - base_synd), 128'(2));
        check_output("b2b_abort", 128'(abort_cnt - base_abort), '0);
        check_frame("b2b", '0, 1'b0);

        // Case 2: single 01 on the highest-degree symbol
        clear_cw();
        cw[0] = 8'h01;
        apply_stimulus(255, 1'b0);
        go_idle(3);
        check_output("x254_s0", 128'(synd_cap[7:0]), 128'(8'h01));
        check_output("x254_s1", 128'(synd_cap[15:8]), 128'(8'h8E));
        check_output("x254_s2", 128'(synd_cap[23:16]), 128'(8'h47));
        check_frame("x254", model_synd(), 1'b1);

        // Case 3: single 01 on the constant term
        clear_cw();
        cw[254] = 8'h01;
        apply_stimulus(255, 1'b0);
        go_idle(3);
        check_frame("x0", {16{8'h01}}, 1'b1);

        // Case 4: sop again mid-frame, then a full corrupted codeword
        encode_random();
        cw[7] = cw[7] ^ 8'h05;
        exp = model_synd();
        snapshot();
        apply_stimulus(100, 1'b0);
        apply_stimulus(255, 1'b0);
        go_idle(3);
        check_output("abort_cnt", 128'(abort_cnt - base_abort), 128'(1));
        check_output("abort_synd_cnt", 128'(synd_cnt - base_synd), 128'(1));
        check_frame("abort", exp, 1'b1);

        // Case 5: valid codeword with random input gaps
        encode_random();
        snapshot();
        apply_stimulus(255, 1'b1);
        go_idle(3);
        check_output("gap_synd_cnt", 128'(synd_cnt - base_synd), 128'(1));
        check_frame("gap", '0, 1'b0);
        check_output("gap_latency", 128'(synd_cyc - last_cyc), 128'(1));
        check_output("gap_dout_bad", 128'(dout_bad - base_bad), '0);

        // Case 6: reset partway through a frame, then a clean frame
        cw[200] = cw[200] ^ 8'h80;
        exp = model_synd();
        snapshot();
        apply_stimulus(50, 1'b0);
        @(negedge clk);
        din_val = 1'b0;
        din_sop = 1'b0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rstmid_synd_cnt", 128'(synd_cnt - base_synd), '0);
        check_output("rstmid_abort", 128'(abort_cnt - base_abort), '0);
        check_output("rstmid_synd", synd, '0);
        snapshot();
        apply_stimulus(255, 1'b0);
        go_idle(3);
        check_output("post_rst_synd_cnt", 128'(synd_cnt - base_synd), 128'(1));
        check_frame("post_rst", exp, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
